// File: rtl/address_ram_map_pkg.sv
// Shared constants, types and the region-base helper for the network-parameter
// database address map.
package neuroset_pkg;

   localparam int ADDR_W = 13;
   localparam int STEP_W = 5;

   // Step numbers that load a region of the database.
   localparam logic [STEP_W-1:0] STEP_PIX = 5'd1;
   localparam logic [STEP_W-1:0] STEP_W2  = 5'd2;
   localparam logic [STEP_W-1:0] STEP_W4  = 5'd4;
   localparam logic [STEP_W-1:0] STEP_W6  = 5'd6;
   localparam logic [STEP_W-1:0] STEP_W8  = 5'd8;
   localparam logic [STEP_W-1:0] STEP_W10 = 5'd10;
   localparam logic [STEP_W-1:0] STEP_W12 = 5'd12;
   localparam logic [STEP_W-1:0] STEP_W14 = 5'd14;

   // One row of the address map: inclusive window plus the load flag.
   typedef struct packed {
      logic [ADDR_W-1:0] first;
      logic [ADDR_W-1:0] last;
      logic              re;
   } map_entry_t;

   // Base address of the region loaded in step 'region'. Regions are laid out
   // in step order, each weight region preceded by a 'gap'-word guard band.
   // Used only at elaboration time.
   function automatic int unsigned region_base(
      input int unsigned region,
      input int unsigned pix_words,
      input int unsigned gap,
      input int unsigned len_s2,
      input int unsigned len_s4,
      input int unsigned len_s6,
      input int unsigned len_s8,
      input int unsigned len_s10,
      input int unsigned len_s12
   );
      int unsigned base;
      base = 0;
      if (region >= 2)  base = pix_words + gap;
      if (region >= 4)  base = base + len_s2 + gap;
      if (region >= 6)  base = base + len_s4 + gap;
      if (region >= 8)  base = base + len_s6 + gap;
      if (region >= 10) base = base + len_s8 + gap;
      if (region >= 12) base = base + len_s10 + gap;
      if (region >= 14) base = base + len_s12 + gap;
      return base;
   endfunction

endpackage

// File: rtl/address_ram_map_if.sv
// Step-in / window-out bundle between the sequencer and the address map.
// There is no valid/ready handshake: the sequencer holds 'step' for many
// cycles and the window outputs follow it one clock later, so the loader
// simply waits a cycle after every step change before using them.
interface address_ram_map_if;
   import neuroset_pkg::*;

   logic [STEP_W-1:0] step;
   logic [ADDR_W-1:0] firstaddr;
   logic [ADDR_W-1:0] lastaddr;
   logic              re_RAM;

   // Sequencer / loader side.
   modport master (
      output step,
      input  firstaddr,
      input  lastaddr,
      input  re_RAM
   );

   // Address-map side.
   modport slave (
      input  step,
      output firstaddr,
      output lastaddr,
      output re_RAM
   );
endinterface

// File: rtl/address_ram_map_lut.sv
// Combinational step -> {first, last, re} lookup. All windows are
// elaboration-time constants; the only runtime logic is the step select.
module address_ram_lut
   import neuroset_pkg::*;
#(
   parameter int unsigned picture_size     = 28,
   parameter int unsigned convolution_size = 0,
   parameter int unsigned LEN_S2           = 36,
   parameter int unsigned LEN_S4           = 144,
   parameter int unsigned LEN_S6           = 288,
   parameter int unsigned LEN_S8           = 576,
   parameter int unsigned LEN_S10          = 576,
   parameter int unsigned LEN_S12          = 1152,
   parameter int unsigned LEN_S14          = 1760
) (
   input  logic [STEP_W-1:0] step,
   output map_entry_t        entry
);

   localparam int unsigned PIX_WORDS = picture_size * picture_size;

   localparam int unsigned B2  = region_base(2,  PIX_WORDS, convolution_size,
      LEN_S2, LEN_S4, LEN_S6, LEN_S8, LEN_S10, LEN_S12);
   localparam int unsigned B4  = region_base(4,  PIX_WORDS, convolution_size,
      LEN_S2, LEN_S4, LEN_S6, LEN_S8, LEN_S10, LEN_S12);
   localparam int unsigned B6  = region_base(6,  PIX_WORDS, convolution_size,
      LEN_S2, LEN_S4, LEN_S6, LEN_S8, LEN_S10, LEN_S12);
   localparam int unsigned B8  = region_base(8,  PIX_WORDS, convolution_size,
      LEN_S2, LEN_S4, LEN_S6, LEN_S8, LEN_S10, LEN_S12);
   localparam int unsigned B10 = region_base(10, PIX_WORDS, convolution_size,
      LEN_S2, LEN_S4, LEN_S6, LEN_S8, LEN_S10, LEN_S12);
   localparam int unsigned B12 = region_base(12, PIX_WORDS, convolution_size,
      LEN_S2, LEN_S4, LEN_S6, LEN_S8, LEN_S10, LEN_S12);
   localparam int unsigned B14 = region_base(14, PIX_WORDS, convolution_size,
      LEN_S2, LEN_S4, LEN_S6, LEN_S8, LEN_S10, LEN_S12);

   localparam int unsigned MAX_ADDR = (1 << ADDR_W) - 1;

   // The whole database must fit the address bus and every region must be
   // non-empty, otherwise 'last' would underflow or wrap.
   if (B14 + LEN_S14 - 1 > MAX_ADDR) begin : g_addr_overflow
      $error("address_ram_lut: database end %0d exceeds %0d-bit address range",
             B14 + LEN_S14 - 1, ADDR_W);
   end
   if (LEN_S2 == 0 || LEN_S4 == 0 || LEN_S6 == 0 || LEN_S8 == 0 ||
       LEN_S10 == 0 || LEN_S12 == 0 || LEN_S14 == 0) begin : g_empty_region
      $error("address_ram_lut: every LEN_S* must be at least 1");
   end
   if (PIX_WORDS == 0) begin : g_empty_picture
      $error("address_ram_lut: picture_size must be at least 1");
   end

   localparam logic [ADDR_W-1:0] F2  = ADDR_W'(B2);
   localparam logic [ADDR_W-1:0] F4  = ADDR_W'(B4);
   localparam logic [ADDR_W-1:0] F6  = ADDR_W'(B6);
   localparam logic [ADDR_W-1:0] F8  = ADDR_W'(B8);
   localparam logic [ADDR_W-1:0] F10 = ADDR_W'(B10);
   localparam logic [ADDR_W-1:0] F12 = ADDR_W'(B12);
   localparam logic [ADDR_W-1:0] F14 = ADDR_W'(B14);

   localparam logic [ADDR_W-1:0] L1  = ADDR_W'(PIX_WORDS - 1);
   localparam logic [ADDR_W-1:0] L2  = ADDR_W'(B2  + LEN_S2  - 1);
   localparam logic [ADDR_W-1:0] L4  = ADDR_W'(B4  + LEN_S4  - 1);
   localparam logic [ADDR_W-1:0] L6  = ADDR_W'(B6  + LEN_S6  - 1);
   localparam logic [ADDR_W-1:0] L8  = ADDR_W'(B8  + LEN_S8  - 1);
   localparam logic [ADDR_W-1:0] L10 = ADDR_W'(B10 + LEN_S10 - 1);
   localparam logic [ADDR_W-1:0] L12 = ADDR_W'(B12 + LEN_S12 - 1);
   localparam logic [ADDR_W-1:0] L14 = ADDR_W'(B14 + LEN_S14 - 1);

   // Select the window for the current step; compute and unused steps map to
   // an all-zero, non-loading entry.
   always_comb begin
      entry = '0;
      case (step)
         STEP_PIX: entry = '{first: '0,  last: L1,  re: 1'b1};
         STEP_W2:  entry = '{first: F2,  last: L2,  re: 1'b1};
         STEP_W4:  entry = '{first: F4,  last: L4,  re: 1'b1};
         STEP_W6:  entry = '{first: F6,  last: L6,  re: 1'b1};
         STEP_W8:  entry = '{first: F8,  last: L8,  re: 1'b1};
         STEP_W10: entry = '{first: F10, last: L10, re: 1'b1};
         STEP_W12: entry = '{first: F12, last: L12, re: 1'b1};
         STEP_W14: entry = '{first: F14, last: L14, re: 1'b1};
         default:  entry = '0;
      endcase
   end

endmodule

// File: rtl/address_ram_map.sv
// Registered address-map lookup: returns the database window and load flag
// for the sequencer's current step, one clock after the step is sampled.
module address_ram_map
   import neuroset_pkg::*;
#(
   parameter int unsigned picture_size     = 28,
   parameter int unsigned convolution_size = 0,
   parameter int unsigned LEN_S2           = 36,
   parameter int unsigned LEN_S4           = 144,
   parameter int unsigned LEN_S6           = 288,
   parameter int unsigned LEN_S8           = 576,
   parameter int unsigned LEN_S10          = 576,
   parameter int unsigned LEN_S12          = 1152,
   parameter int unsigned LEN_S14          = 1760
) (
   input  logic              clk,
   input  logic              rst_n,
   address_ram_map_if.slave  bus
);

   map_entry_t lut_entry;
   map_entry_t map_q;

   address_ram_lut #(
      .picture_size     (picture_size),
      .convolution_size (convolution_size),
      .LEN_S2           (LEN_S2),
      .LEN_S4           (LEN_S4),
      .LEN_S6           (LEN_S6),
      .LEN_S8           (LEN_S8),
      .LEN_S10          (LEN_S10),
      .LEN_S12          (LEN_S12),
      .LEN_S14          (LEN_S14)
   ) u_lut (
      .step  (bus.step),
      .entry (lut_entry)
   );

   // Capture the looked-up window each cycle; reset clears it at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         map_q <= '0;
      end else begin
         map_q <= lut_entry;
      end
   end

   assign bus.firstaddr = map_q.first;
   assign bus.lastaddr  = map_q.last;
   assign bus.re_RAM    = map_q.re;

endmodule

// File: tb/tb_address_ram_map.sv
// Directed bench for address_ram_map: default map, gap variant, latency and
// asynchronous reset behaviour.
module tb_address_ram_map;
   import neuroset_pkg::*;

   logic clk;
   logic rst_n;

   int checks   = 0;
   int failures = 0;

   address_ram_map_if bus_d ();
   address_ram_map_if bus_g ();

   address_ram_map u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_d.slave)
   );

   address_ram_map #(.convolution_size(4)) u_dut_gap (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_g.slave)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard compare
   task automatic check(input string tag, input logic [ADDR_W-1:0] obs,
                        input logic [ADDR_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_win(input string tag, input logic [ADDR_W-1:0] f,
                            input logic [ADDR_W-1:0] l, input logic r,
                            input logic [ADDR_W-1:0] ef,
                            input logic [ADDR_W-1:0] el, input logic er);
      check({tag, ".first"}, f, ef);
      check({tag, ".last"},  l, el);
      check({tag, ".re"},    {{(ADDR_W-1){1'b0}}, r}, {{(ADDR_W-1){1'b0}}, er});
   endtask

   // Driver: change step away from the edge, let one edge pass, sample after.
   task automatic apply_step(input logic [STEP_W-1:0] s);
      @(negedge clk);
      bus_d.step = s;
      bus_g.step = s;
      @(posedge clk);
      #1;
   endtask

   // Hand-computed default windows for load steps
   logic [STEP_W-1:0] ld_step [8] = '{5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14};
   logic [ADDR_W-1:0] ld_first[8] = '{13'd0, 13'd784, 13'd820, 13'd964, 13'd1252,
                                      13'd1828, 13'd2404, 13'd3556};
   logic [ADDR_W-1:0] ld_last [8] = '{13'd783, 13'd819, 13'd963, 13'd1251, 13'd1827,
                                      13'd2403, 13'd3555, 13'd5315};
   logic [STEP_W-1:0] idle_step[6] = '{5'd0, 5'd3, 5'd7, 5'd13, 5'd15, 5'd31};

   initial begin
      rst_n      = 1'b1;
      bus_d.step = 5'd1;
      bus_g.step = 5'd1;

      // Run a couple of edges so the registers hold a non-zero window.
      repeat (2) @(posedge clk);
      #1;
      check_win("pre_reset", bus_d.firstaddr, bus_d.lastaddr, bus_d.re_RAM,
                13'd0, 13'd783, 1'b1);

      // Asynchronous reset between edges: outputs clear without a clock.
      #2;
      rst_n = 1'b0;
      #1;
      check_win("async_reset", bus_d.firstaddr, bus_d.lastaddr, bus_d.re_RAM,
                13'd0, 13'd0, 1'b0);
      check_win("async_reset_gap", bus_g.firstaddr, bus_g.lastaddr, bus_g.re_RAM,
                13'd0, 13'd0, 1'b0);
      @(posedge clk);
      #1;
      check_win("held_reset", bus_d.firstaddr, bus_d.lastaddr, bus_d.re_RAM,
                13'd0, 13'd0, 1'b0);

      // Release between edges; first edge loads step 1.
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_win("post_reset", bus_d.firstaddr, bus_d.lastaddr, bus_d.re_RAM,
                13'd0, 13'd783, 1'b1);

      // Walk every load step with default parameters.
      for (int i = 0; i < 8; i++) begin
         apply_step(ld_step[i]);
         check_win($sformatf("load_step%0d", ld_step[i]), bus_d.firstaddr,
                   bus_d.lastaddr, bus_d.re_RAM, ld_first[i], ld_last[i], 1'b1);
      end

      // Compute and unused steps.
      for (int i = 0; i < 6; i++) begin
         apply_step(idle_step[i]);
         check_win($sformatf("idle_step%0d", idle_step[i]), bus_d.firstaddr,
                   bus_d.lastaddr, bus_d.re_RAM, 13'd0, 13'd0, 1'b0);
      end

      // Latency: 1 -> 2, old window persists until the next edge.
      apply_step(5'd1);
      @(negedge clk);
      bus_d.step = 5'd2;
      bus_g.step = 5'd2;
      #1;
      check_win("latency_before", bus_d.firstaddr, bus_d.lastaddr, bus_d.re_RAM,
                13'd0, 13'd783, 1'b1);
      @(posedge clk);
      #1;
      check_win("latency_after", bus_d.firstaddr, bus_d.lastaddr, bus_d.re_RAM,
                13'd784, 13'd819, 1'b1);

      // Gap of 4 words before each weight region.
      check_win("gap_step2", bus_g.firstaddr, bus_g.lastaddr, bus_g.re_RAM,
                13'd788, 13'd823, 1'b1);
      apply_step(5'd4);
      check_win("gap_step4", bus_g.firstaddr, bus_g.lastaddr, bus_g.re_RAM,
                13'd828, 13'd971, 1'b1);
      apply_step(5'd1);
      check_win("gap_step1", bus_g.firstaddr, bus_g.lastaddr, bus_g.re_RAM,
                13'd0, 13'd783, 1'b1);

      // Reset asserted mid-operation on a weight step, then recovery.
      apply_step(5'd14);
      #2;
      rst_n = 1'b0;
      #1;
      check_win("mid_reset", bus_d.firstaddr, bus_d.lastaddr, bus_d.re_RAM,
                13'd0, 13'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_win("mid_reset_recover", bus_d.firstaddr, bus_d.lastaddr, bus_d.re_RAM,
                13'd3556, 13'd5315, 1'b1);

      // Final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/address_ram_map.md
Name: address_ram_map

Overview:
- Registered address-map lookup for the network-parameter database (pixels plus per-layer weights).
- Given the current load/compute step number, it returns the inclusive database address window (firstaddr..lastaddr) that the loader walks during that step.
- It also returns a read-enable flag, re_RAM, marking the step as a database-load step.
- Sits beside the database-to-memory loader, which iterates i over 0..lastaddr-firstaddr and drives address = firstaddr+i.

Parameters:
- picture_size, 28: input image edge in pixels; the pixel region holds picture_size*picture_size words.
- convolution_size, 0: guard gap in words inserted before every weight region; 0 means regions are contiguous.
- LEN_S2, 36: database words loaded in step 2 (conv1 weights).
- LEN_S4, 144: words for step 4.
- LEN_S6, 288: words for step 6.
- LEN_S8, 576: words for step 8.
- LEN_S10, 576: words for step 10.
- LEN_S12, 1152: words for step 12.
- LEN_S14, 1760: words for step 14 (dense weights).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- step  input  5  current step number from the loader/sequencer.
- firstaddr  output  13  first database address of the step's window (registered).
- lastaddr  output  13  last database address of the step's window, inclusive (registered).
- re_RAM  output  1  1 = step is a database-load step (registered).

Behaviour:
- Reset: while rst_n=0, firstaddr=0, lastaddr=0, re_RAM=0, applied asynchronously. Release is synchronous to the next clk edge.
- Latency: outputs reflect the step value sampled at the previous rising edge (1-cycle latency). Step is held constant for many cycles, so no handshake exists.
- Region bases, with P = picture_size*picture_size and g = convolution_size:
  - B1 = 0.
  - B2 = P+g.
  - B4 = B2+LEN_S2+g.
  - B6 = B4+LEN_S4+g.
  - B8 = B6+LEN_S6+g.
  - B10 = B8+LEN_S8+g.
  - B12 = B10+LEN_S10+g.
  - B14 = B12+LEN_S12+g.
- Map:
  - step 1: first=0, last=P-1, re_RAM=1.
  - step k in {2,4,6,8,10,12,14}: first=Bk, last=Bk+LEN_Sk-1, re_RAM=1.
  - All other step values (0, odd 3..13, 15..31): first=0, last=0, re_RAM=0.
- Every base and last address is an elaboration-time constant. No runtime arithmetic beyond a 5-bit case select is required.
- Width rule: B14+LEN_S14-1 must be ≤ 8191. Elaboration fails with a message otherwise.
- Every LEN_Sk must be ≥ 1; otherwise elaboration fails.
- Outputs never wrap or saturate at runtime.
- Step changes mid-window: the new step's window appears on the next edge. No history is kept.
- Reset asserted mid-operation: outputs go to 0 immediately. The first post-reset edge loads the map for the current step.

Decomposition:
- Shared package neuroset_pkg holds:
  - ADDR_W=13 and STEP_W=5.
  - Step-number constants STEP_PIX=1, STEP_W2..STEP_W14.
  - A constant function computing region bases from the parameters.
- One natural combinational sub-module, address_ram_lut: step to {first, last, re}.
- The top registers the sub-module's outputs and owns the reset.

Test Plan:
- Reset: assert rst_n=0 with step=1 -> firstaddr=0, lastaddr=0, re_RAM=0 without waiting for a clock. Release rst_n, one edge -> first=0, last=783, re_RAM=1.
- Walk the load steps with defaults, checking one edge after each change:
  - step 2 -> 784/819.
  - step 4 -> 820/963.
  - step 6 -> 964/1251.
  - step 8 -> 1252/1827.
  - step 10 -> 1828/2403.
  - step 12 -> 2404/3555.
  - step 14 -> 3556/5315.
  - re_RAM=1 for each.
- Compute and invalid steps: step 0, 3, 7, 13, 15, 31 -> first=0, last=0, re_RAM=0.
- Latency: change step 1->2 at an edge -> outputs still show 0/783 until the following edge, then 784/819.
- Gap parameter: convolution_size=4 -> step 2 gives 788/823 and step 4 gives 828/971.
- Overflow check: LEN_S14=8000 -> elaboration error reported.
